// File: rtl/i2c_cond_pkg.sv
// Shared types and line-level helpers for the I2C bus-condition sequencer.
// Commands select START/RSTART/STOP; the state list names every timed phase.
package i2c_cond_pkg;

    typedef enum logic [1:0] {
        CMD_NONE   = 2'b00,
        CMD_START  = 2'b01,
        CMD_STOP   = 2'b10,
        CMD_RSTART = 2'b11
    } cmd_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_HELD,
        S_ST1,
        S_ST2,
        S_ST3,
        S_RS1,
        S_RS2,
        S_RS3,
        S_RS4,
        S_SP1,
        S_SP2,
        S_SP3
    } state_e;

    // {scl, sda} drive intent for each state: 1 = release, 0 = pull low.
    function automatic logic [1:0] line_levels(state_e s);
        logic [1:0] lv;
        case (s)
            S_IDLE:  lv = 2'b11;
            S_HELD:  lv = 2'b00;
            S_ST1:   lv = 2'b11;
            S_ST2:   lv = 2'b10;
            S_ST3:   lv = 2'b00;
            S_RS1:   lv = 2'b01;
            S_RS2:   lv = 2'b11;
            S_RS3:   lv = 2'b10;
            S_RS4:   lv = 2'b00;
            S_SP1:   lv = 2'b00;
            S_SP2:   lv = 2'b10;
            S_SP3:   lv = 2'b11;
            default: lv = 2'b11;
        endcase
        return lv;
    endfunction

    function automatic logic is_rest(state_e s);
        return (s == S_IDLE) || (s == S_HELD);
    endfunction

endpackage

// File: rtl/i2c_cond_seq_if.sv
// Command/bus bundle between the byte engine, the condition sequencer and the
// SCL/SDA output mux.
interface i2c_cond_seq_if #(
    parameter int CNT_W = 16
);
    import i2c_cond_pkg::*;

    logic             cmd_valid;
    cmd_e             cmd;
    logic             cmd_ready;
    logic [CNT_W-1:0] phase_cnt;
    logic             scl_i;
    logic             sda_i;
    logic             scl_o;
    logic             sda_o;
    logic             gen_active;
    logic             bus_own;
    logic             done;
    logic             err;
    logic             arb_lost;

    modport master (
        output cmd_valid, cmd, phase_cnt, scl_i, sda_i,
        input  cmd_ready, scl_o, sda_o, gen_active, bus_own, done, err, arb_lost
    );

    modport slave (
        input  cmd_valid, cmd, phase_cnt, scl_i, sda_i,
        output cmd_ready, scl_o, sda_o, gen_active, bus_own, done, err, arb_lost
    );

endinterface

// File: rtl/i2c_phase_timer.sv
// Phase-length down-counter: loads N-1 on phase entry, expires at zero, and can
// be held at its load value until the observed SCL line goes high.
module i2c_phase_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             stretch,
    input  logic             line_hi,
    output logic             expire
);

    logic [CNT_W-1:0] cnt;
    logic             go;
    logic             hold;

    // Once SCL has been seen high the phase runs to completion regardless of SCL.
    assign hold   = stretch & ~go & ~line_hi;
    assign expire = (cnt == '0) & ~hold;

    always_ff @(posedge clk) begin
        if (load) begin
            cnt <= load_val;
        end else if (!hold && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            go <= 1'b0;
        end else if (load) begin
            go <= 1'b0;
        end else if (line_hi) begin
            go <= 1'b1;
        end
    end

endmodule

// File: rtl/i2c_cond_seq.sv
// Timed I2C START / repeated START / STOP generator with clock-stretch wait,
// arbitration check and bus-ownership tracking; all outputs are registered.
module i2c_cond_seq
    import i2c_cond_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter bit STRETCH_EN = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    i2c_cond_seq_if.slave  bus
);

    state_e           state;
    state_e           state_next;
    logic             accept;
    logic             expire;
    logic             load;
    logic             stretch_ph;
    logic             own_next;
    logic             done_next;
    logic             err_next;
    logic             arb_next;
    logic [CNT_W-1:0] n_m1;
    logic [CNT_W-1:0] n_in;
    logic [CNT_W-1:0] load_val;

    assign accept     = bus.cmd_valid & bus.cmd_ready;
    assign n_in       = (bus.phase_cnt == '0) ? '0 : bus.phase_cnt - CNT_W'(1);
    // The first phase loads straight from the port; later phases use the latched copy.
    assign load_val   = accept ? n_in : n_m1;
    assign stretch_ph = STRETCH_EN && ((state == S_RS2) || (state == S_SP2));

    i2c_phase_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .load_val(load_val),
        .stretch (stretch_ph),
        .line_hi (bus.scl_i),
        .expire  (expire)
    );

    always_ff @(posedge clk) begin
        if (accept) begin
            n_m1 <= n_in;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        own_next   = bus.bus_own;
        done_next  = 1'b0;
        err_next   = 1'b0;
        arb_next   = 1'b0;
        case (state)
            S_IDLE, S_HELD: begin
                if (accept) begin
                    case (bus.cmd)
                        CMD_START: begin
                            if (!bus.bus_own) begin
                                state_next = S_ST1;
                                load       = 1'b1;
                            end else begin
                                err_next = 1'b1;
                            end
                        end
                        CMD_RSTART: begin
                            if (bus.bus_own) begin
                                state_next = S_RS1;
                                load       = 1'b1;
                            end else begin
                                err_next = 1'b1;
                            end
                        end
                        CMD_STOP: begin
                            if (bus.bus_own) begin
                                state_next = S_SP1;
                                load       = 1'b1;
                            end else begin
                                err_next = 1'b1;
                            end
                        end
                        default: err_next = 1'b1;
                    endcase
                end
            end
            S_ST1: begin
                if (expire) begin
                    // Another master or a held SCL means the bus was not free.
                    if (!bus.sda_i || !bus.scl_i) begin
                        state_next = S_IDLE;
                        arb_next   = 1'b1;
                        own_next   = 1'b0;
                    end else begin
                        state_next = S_ST2;
                        load       = 1'b1;
                    end
                end
            end
            S_ST2: begin
                if (expire) begin
                    state_next = S_ST3;
                    load       = 1'b1;
                end
            end
            S_ST3: begin
                if (expire) begin
                    state_next = S_HELD;
                    done_next  = 1'b1;
                    own_next   = 1'b1;
                end
            end
            S_RS1: begin
                if (expire) begin
                    state_next = S_RS2;
                    load       = 1'b1;
                end
            end
            S_RS2: begin
                if (expire) begin
                    if (!bus.sda_i) begin
                        state_next = S_IDLE;
                        arb_next   = 1'b1;
                        own_next   = 1'b0;
                    end else begin
                        state_next = S_RS3;
                        load       = 1'b1;
                    end
                end
            end
            S_RS3: begin
                if (expire) begin
                    state_next = S_RS4;
                    load       = 1'b1;
                end
            end
            S_RS4: begin
                if (expire) begin
                    state_next = S_HELD;
                    done_next  = 1'b1;
                    own_next   = 1'b1;
                end
            end
            S_SP1: begin
                if (expire) begin
                    state_next = S_SP2;
                    load       = 1'b1;
                end
            end
            S_SP2: begin
                if (expire) begin
                    state_next = S_SP3;
                    load       = 1'b1;
                end
            end
            S_SP3: begin
                if (expire) begin
                    state_next = S_IDLE;
                    own_next   = 1'b0;
                    if (!bus.sda_i) begin
                        arb_next = 1'b1;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they change with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            bus.scl_o      <= 1'b1;
            bus.sda_o      <= 1'b1;
            bus.gen_active <= 1'b0;
            bus.bus_own    <= 1'b0;
            bus.done       <= 1'b0;
            bus.err        <= 1'b0;
            bus.arb_lost   <= 1'b0;
            bus.cmd_ready  <= 1'b0;
        end else begin
            state                  <= state_next;
            {bus.scl_o, bus.sda_o} <= line_levels(state_next);
            bus.gen_active         <= ~is_rest(state_next);
            bus.bus_own            <= own_next;
            bus.done               <= done_next;
            bus.err                <= err_next;
            bus.arb_lost           <= arb_next;
            bus.cmd_ready          <= is_rest(state_next) & ~done_next & ~arb_next;
        end
    end

endmodule

// File: tb/tb_i2c_cond_seq.sv
// Bench for i2c_cond_seq: directed condition scenarios followed by random
// command sequences, all compared cycle by cycle against a phase-list model.
module tb_i2c_cond_seq;
    import i2c_cond_pkg::*;

    localparam int CNT_W = 16;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_pass;
    logic own_m;

    i2c_cond_seq_if #(.CNT_W(CNT_W)) bus ();

    i2c_cond_seq #(
        .CNT_W     (CNT_W),
        .STRETCH_EN(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed vector layout: {scl_o, sda_o, gen_active, done, arb_lost, err, bus_own, cmd_ready}
    function automatic logic [7:0] obs();
        return {bus.scl_o, bus.sda_o, bus.gen_active, bus.done,
                bus.arb_lost, bus.err, bus.bus_own, bus.cmd_ready};
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %b expected %b (scl sda gen done arb err own rdy)",
                     tag, got, exp);
        end
    endtask

    // arb: 0 none, 1 SDA pulled low in the checked phase, 2 SCL low at end of ST1.
    // rst_at: cycle (after accept) in which reset is asserted, -1 for none.
    task automatic run_cmd(input string name, input cmd_e cmd, input int pc,
                           input int s_extra, input int arb, input int rst_at);
        logic [1:0] lv [4];
        int         len [4];
        int         st [4];
        int         nph, sidx, aidx, n, t_end, ac, last, guard, k;
        logic       legal, own_after;
        logic [1:0] fin;
        logic [7:0] exp;

        legal = ((cmd == CMD_START) && !own_m) ||
                (((cmd == CMD_RSTART) || (cmd == CMD_STOP)) && own_m);
        n = (pc == 0) ? 1 : pc;
        nph = 3; sidx = -1; aidx = 0; fin = 2'b00; own_after = 1'b1;
        lv[3] = 2'b00;
        case (cmd)
            CMD_START: begin
                lv[0] = 2'b11; lv[1] = 2'b10; lv[2] = 2'b00; aidx = 0;
            end
            CMD_RSTART: begin
                nph = 4; lv[0] = 2'b01; lv[1] = 2'b11; lv[2] = 2'b10; lv[3] = 2'b00;
                sidx = 1; aidx = 1;
            end
            default: begin
                lv[0] = 2'b00; lv[1] = 2'b10; lv[2] = 2'b11;
                sidx = 1; aidx = 2; fin = 2'b11; own_after = 1'b0;
            end
        endcase
        t_end = 0;
        for (int p = 0; p < nph; p++) begin
            st[p]  = t_end;
            len[p] = n + ((p == sidx) ? s_extra : 0);
            t_end += len[p];
        end
        ac = st[aidx] + len[aidx];
        if (!legal) last = 1;
        else if (arb != 0) last = ac + 1;
        else last = t_end + 1;
        if ((rst_at >= 0) && (rst_at < last)) last = rst_at;

        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b1;
        bus.cmd       = cmd;
        bus.phase_cnt = CNT_W'(pc);
        guard = 0;
        while ((bus.cmd_ready !== 1'b1) && (guard < 20)) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 20) begin
            check({name, " ready_wait"}, {7'b0, bus.cmd_ready}, 8'd1);
            bus.cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);

        for (int c = 0; c <= last; c++) begin
            if (c > 0) @(posedge clk);
            #1;
            if (c == 0) begin
                bus.cmd_valid = 1'b0;
                bus.phase_cnt = CNT_W'($urandom);
            end
            bus.scl_i = 1'b1;
            bus.sda_i = 1'b1;
            if (legal && (c < t_end)) begin
                if ((sidx >= 0) && (c >= st[sidx]) && (c < st[sidx] + s_extra)) bus.scl_i = 1'b0;
                if ((arb == 2) && (c == ac - 1)) bus.scl_i = 1'b0;
                if ((arb == 1) && (c == ac - 1)) bus.sda_i = 1'b0;
            end
            if (c == rst_at) rst = 1'b1;
            @(negedge clk);
            if (!legal) begin
                exp = {(own_m ? 2'b00 : 2'b11), 3'b000, (c == 0), own_m, 1'b1};
            end else if ((arb != 0) && (c >= ac)) begin
                exp = {2'b11, 2'b00, (c == ac), 2'b00, (c == ac + 1)};
            end else if (c < t_end) begin
                k = 0;
                while ((k < nph - 1) && (c >= st[k] + len[k])) k++;
                exp = {lv[k], 1'b1, 3'b000, own_m, 1'b0};
            end else begin
                exp = {fin, 1'b0, (c == t_end), 2'b00, own_after, (c == t_end + 1)};
            end
            check($sformatf("%s c%0d", name, c), obs(), exp);
        end

        if ((rst_at >= 0) && (rst_at <= last)) begin
            @(posedge clk);
            #1;
            rst = 1'b0;
            bus.scl_i = 1'b1;
            bus.sda_i = 1'b1;
            @(negedge clk);
            check({name, " in_reset"}, obs(), 8'b1100_0000);
            @(posedge clk);
            @(negedge clk);
            check({name, " after_reset"}, obs(), 8'b1100_0001);
            own_m = 1'b0;
        end else if (legal) begin
            own_m = (arb != 0) ? 1'b0 : own_after;
        end
        bus.scl_i = 1'b1;
        bus.sda_i = 1'b1;
    endtask

    initial begin
        logic [1:0] rc;
        cmd_e       c;
        int         arb;

        n_chk = 0;
        n_pass = 0;
        own_m = 1'b0;
        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd = CMD_NONE;
        bus.phase_cnt = '0;
        bus.scl_i = 1'b1;
        bus.sda_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_state", obs(), 8'b1100_0000);
        @(posedge clk);
        @(negedge clk);
        check("ready_after_reset", obs(), 8'b1100_0001);

        run_cmd("start_n4", CMD_START, 4, 0, 0, -1);
        run_cmd("rstart_n3_s5", CMD_RSTART, 3, 5, 0, -1);
        run_cmd("stop_n2", CMD_STOP, 2, 0, 0, -1);
        run_cmd("start_arb_sda", CMD_START, 5, 0, 1, -1);
        run_cmd("stop_unowned", CMD_STOP, 3, 0, 0, -1);
        run_cmd("cmd_none", CMD_NONE, 3, 0, 0, -1);
        run_cmd("start_n0", CMD_START, 0, 0, 0, -1);
        run_cmd("start_owned", CMD_START, 2, 0, 0, -1);
        run_cmd("rstart_arb", CMD_RSTART, 2, 2, 1, -1);
        run_cmd("start_arb_scl", CMD_START, 3, 0, 2, -1);
        run_cmd("start_n2", CMD_START, 2, 0, 0, -1);
        run_cmd("rstart_reset", CMD_RSTART, 3, 0, 0, 7);
        run_cmd("start_n1", CMD_START, 1, 0, 0, -1);
        run_cmd("stop_arb", CMD_STOP, 2, 1, 1, -1);

        for (int i = 0; i < 40; i++) begin
            rc = 2'($urandom_range(0, 3));
            c = cmd_e'(rc);
            arb = ($urandom_range(0, 5) == 0) ? 1 : 0;
            if ((arb == 1) && (c == CMD_START) && ($urandom_range(0, 1) == 1)) arb = 2;
            run_cmd($sformatf("rnd%0d", i), c, int'($urandom_range(0, 5)),
                    int'($urandom_range(0, 4)), arb, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
